// File: rtl/aes128_core_dual.sv
// Iterative AES-128 encrypt/decrypt core with an internal key expander and a
// one-entry cache of the last expanded schedule; START/DONE level handshake.
module aes128_core_dual #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit KEY_CACHE      = 1'b1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         AES_START,
    input  logic         AES_MODE,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_IN,
    output logic [127:0] AES_MSG_OUT,
    output logic         AES_DONE,
    output logic         AES_BUSY,
    output logic         KEY_HIT
);
    localparam int M = 4 / COLS_PER_CYCLE;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_KEYEXP = 4'd1;
    localparam logic [3:0] S_INIT   = 4'd2;
    localparam logic [3:0] S_SBSR   = 4'd3;
    localparam logic [3:0] S_ARK    = 4'd4;
    localparam logic [3:0] S_MIX    = 4'd5;
    localparam logic [3:0] S_FSB    = 4'd6;
    localparam logic [3:0] S_FARK   = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    // Forward and inverse S-box share the inverter; only the affine step differs.
    function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic enc);
        logic [7:0] b;
        if (enc) begin
            b = ginv(x);
            return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        b = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic enc);
        logic [7:0] a [4];
        logic [7:0] c [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
        c = enc ? '{8'h02, 8'h03, 8'h01, 8'h01} : '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int i = 0; i < 4; i++)
            r[31-8*i -: 8] = gmul(a[i], c[0]) ^ gmul(a[(i+1)%4], c[1])
                           ^ gmul(a[(i+2)%4], c[2]) ^ gmul(a[(i+3)%4], c[3]);
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
            4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
            4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
            default: return 8'h36;
        endcase
    endfunction

    logic [3:0]   state_q, state_d;
    logic         mode_q, mode_d;
    logic [127:0] key_q, key_d;
    logic [127:0] data_q, data_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic         cache_valid_q, cache_valid_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   mix_q, mix_d;
    logic [5:0]   kw_q, kw_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         key_hit_q, key_hit_d;
    logic [127:0] msg_out_q, msg_out_d;
    logic [31:0]  w_q [4:43];

    logic [31:0]  sched [44];
    logic [31:0]  w_prev, w_new, subw;
    logic [3:0]   rk_idx;
    logic [127:0] rk, sbsr, mixed;
    logic         cache_match, round_last;

    // Words 0..3 of the schedule are the latched key itself.
    always_comb begin
        for (int i = 0; i < 4; i++) sched[i] = key_q[127-32*i -: 32];
        for (int i = 4; i < 44; i++) sched[i] = w_q[i];
    end

    always_comb begin
        w_prev = sched[kw_q - 6'd1];
        for (int i = 0; i < 4; i++) subw[31-8*i -: 8] = sub_byte(w_prev[31-8*((i+1)%4) -: 8], 1'b1);
        if (kw_q[1:0] == 2'd0) w_new = sched[kw_q - 6'd4] ^ subw ^ {rcon(kw_q[5:2]), 24'h0};
        else                   w_new = sched[kw_q - 6'd4] ^ w_prev;
    end

    always_comb begin
        case (state_q)
            S_INIT:  rk_idx = mode_q ? 4'd0 : 4'd10;
            S_ARK:   rk_idx = mode_q ? round_q : 4'd10 - round_q;
            S_FARK:  rk_idx = mode_q ? 4'd10 : 4'd0;
            default: rk_idx = 4'd0;
        endcase
        rk = {sched[{rk_idx, 2'b00}], sched[{rk_idx, 2'b01}],
              sched[{rk_idx, 2'b10}], sched[{rk_idx, 2'b11}]};
    end

    // Byte k of the state is data[127-8k -: 8], column-major (k = 4*col + row).
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                int src;
                src = mode_q ? (c + r) % 4 : (c - r + 4) % 4;
                sbsr[127-8*(4*c+r) -: 8] = sub_byte(data_q[127-8*(4*src+r) -: 8], mode_q);
            end
        end
        mixed = data_q;
        for (int c = 0; c < 4; c++)
            if (c / COLS_PER_CYCLE == int'(mix_q))
                mixed[127-32*c -: 32] = mix_col(data_q[127-32*c -: 32], mode_q);
    end

    assign cache_match = KEY_CACHE && cache_valid_q && (AES_KEY == cache_key_q);
    assign round_last  = (round_q == 4'd9);

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;  mode_d = mode_q;  key_d = key_q;  data_d = data_q;
        cache_key_d = cache_key_q;  cache_valid_d = cache_valid_q;
        round_d = round_q;  mix_d = mix_q;  kw_d = kw_q;
        busy_d = busy_q;  done_d = done_q;  key_hit_d = key_hit_q;  msg_out_d = msg_out_q;
        case (state_q)
            S_IDLE: if (AES_START && !done_q) begin
                mode_d = AES_MODE;  key_d = AES_KEY;  data_d = AES_MSG_IN;
                busy_d = 1'b1;  key_hit_d = cache_match;
                if (cache_match) begin
                    state_d = S_INIT;
                end else begin
                    state_d = S_KEYEXP;  kw_d = 6'd4;  cache_valid_d = 1'b0;
                end
            end
            S_KEYEXP: begin
                kw_d = kw_q + 6'd1;
                if (kw_q == 6'd43) begin
                    state_d = S_INIT;  cache_key_d = key_q;  cache_valid_d = 1'b1;
                end
            end
            S_INIT: begin
                data_d = data_q ^ rk;  round_d = 4'd1;  state_d = S_SBSR;
            end
            S_SBSR: begin
                data_d = sbsr;  mix_d = 2'd0;  state_d = mode_q ? S_MIX : S_ARK;
            end
            S_MIX: begin
                data_d = mixed;  mix_d = mix_q + 2'd1;
                if (mix_q == 2'(M - 1)) begin
                    if (mode_q) begin
                        state_d = S_ARK;
                    end else begin
                        state_d = round_last ? S_FSB : S_SBSR;
                        round_d = round_last ? round_q : round_q + 4'd1;
                    end
                end
            end
            S_ARK: begin
                data_d = data_q ^ rk;
                if (mode_q) begin
                    state_d = round_last ? S_FSB : S_SBSR;
                    round_d = round_last ? round_q : round_q + 4'd1;
                end else begin
                    state_d = S_MIX;  mix_d = 2'd0;
                end
            end
            S_FSB: begin
                data_d = sbsr;  state_d = S_FARK;
            end
            S_FARK: begin
                msg_out_d = data_q ^ rk;  done_d = 1'b1;  busy_d = 1'b0;  state_d = S_DONE;
            end
            S_DONE: if (!AES_START) begin
                done_d = 1'b0;  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;  mode_q <= 1'b0;  cache_valid_q <= 1'b0;
            round_q <= 4'd0;  mix_q <= 2'd0;  kw_q <= 6'd0;
            busy_q <= 1'b0;  done_q <= 1'b0;  key_hit_q <= 1'b0;  msg_out_q <= '0;
        end else begin
            state_q <= state_d;  mode_q <= mode_d;  cache_valid_q <= cache_valid_d;
            round_q <= round_d;  mix_q <= mix_d;  kw_q <= kw_d;
            busy_q <= busy_d;  done_q <= done_d;  key_hit_q <= key_hit_d;  msg_out_q <= msg_out_d;
        end
    end

    // NOTE: the schedule and datapath are not reset; cache_valid_q and the FSM gate every use.
    always_ff @(posedge CLK) begin
        key_q       <= key_d;
        data_q      <= data_d;
        cache_key_q <= cache_key_d;
        if (state_q == S_KEYEXP) w_q[kw_q] <= w_new;
    end

    assign AES_MSG_OUT = msg_out_q;
    assign AES_DONE    = done_q;
    assign AES_BUSY    = busy_q;
    assign KEY_HIT     = key_hit_q;
endmodule

// File: tb/tb_aes128_core_dual.sv
// Directed bench: three builds (1 col/cycle, 4 cols/cycle, no key cache) share one stimulus stream.
module tb_aes128_core_dual;
    logic         CLK = 1'b0;
    logic         RESET;
    logic         start, mode;
    logic [127:0] key, msg_in;
    logic [127:0] out1, out4, outn;
    logic         done1, done4, donen, busy1, busy4, busyn, hit1, hit4, hitn;
    int           checks = 0;
    int           failures = 0;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    always #5 CLK = ~CLK;

    aes128_core_dual #(.COLS_PER_CYCLE(1), .KEY_CACHE(1'b1)) dut1 (
        .CLK(CLK), .RESET(RESET), .AES_START(start), .AES_MODE(mode), .AES_KEY(key),
        .AES_MSG_IN(msg_in), .AES_MSG_OUT(out1), .AES_DONE(done1), .AES_BUSY(busy1), .KEY_HIT(hit1));
    aes128_core_dual #(.COLS_PER_CYCLE(4), .KEY_CACHE(1'b1)) dut4 (
        .CLK(CLK), .RESET(RESET), .AES_START(start), .AES_MODE(mode), .AES_KEY(key),
        .AES_MSG_IN(msg_in), .AES_MSG_OUT(out4), .AES_DONE(done4), .AES_BUSY(busy4), .KEY_HIT(hit4));
    aes128_core_dual #(.COLS_PER_CYCLE(1), .KEY_CACHE(1'b0)) dutn (
        .CLK(CLK), .RESET(RESET), .AES_START(start), .AES_MODE(mode), .AES_KEY(key),
        .AES_MSG_IN(msg_in), .AES_MSG_OUT(outn), .AES_DONE(donen), .AES_BUSY(busyn), .KEY_HIT(hitn));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [127:0] exp);
        chk({tag, " out1"}, out1, exp);
        chk({tag, " out4"}, out4, exp);
        chk({tag, " outn"}, outn, exp);
    endtask

    // Starts an operation and measures edges from acceptance to DONE for each build.
    task automatic run_op(input string tag, input logic m, input logic [127:0] k,
                          input logic [127:0] msg, input logic [127:0] exp,
                          input int l1, input int l4, input int ln,
                          input logic h1, input logic h4, input logic hn);
        int ec, g1, g4, gn;
        @(negedge CLK);
        mode = m;  key = k;  msg_in = msg;  start = 1'b1;
        @(posedge CLK);
        #1;
        chk({tag, " busy_after_accept"}, {busy1, busy4, busyn}, 3'b111);
        chk({tag, " key_hit"}, {hit1, hit4, hitn}, {h1, h4, hn});
        ec = 0;  g1 = -1;  g4 = -1;  gn = -1;
        while ((g1 < 0 || g4 < 0 || gn < 0) && ec < 200) begin
            @(posedge CLK);
            ec++;
            #1;
            if (g1 < 0 && done1) g1 = ec;
            if (g4 < 0 && done4) g4 = ec;
            if (gn < 0 && donen) gn = ec;
            if (ec == 3) begin
                key = ~key;  msg_in = ~msg_in;  mode = ~mode;
            end
        end
        chk({tag, " latency1"}, 128'(g1), 128'(l1));
        chk({tag, " latency4"}, 128'(g4), 128'(l4));
        chk({tag, " latencyn"}, 128'(gn), 128'(ln));
        chk_outs(tag, exp);
        chk({tag, " busy_at_done"}, {busy1, busy4, busyn}, 3'b000);
        chk({tag, " key_hit_held"}, {hit1, hit4, hitn}, {h1, h4, hn});
    endtask

    task automatic release_start(input string tag, input logic [127:0] held);
        @(negedge CLK);
        start = 1'b0;
        @(posedge CLK);
        #1;
        chk({tag, " done_cleared"}, {done1, done4, donen}, 3'b000);
        chk_outs({tag, " held"}, held);
    endtask

    initial begin
        RESET = 1'b1;  start = 1'b0;  mode = 1'b0;  key = '0;  msg_in = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset done", {done1, done4, donen}, 3'b000);
        chk("reset busy", {busy1, busy4, busyn}, 3'b000);
        chk("reset hit", {hit1, hit4, hitn}, 3'b000);
        chk_outs("reset", '0);
        @(negedge CLK);
        RESET = 1'b0;

        run_op("dec_a", 1'b0, KEY_A, CT_A, PT_A, 97, 70, 97, 1'b0, 1'b0, 1'b0);
        release_start("dec_a", PT_A);
        run_op("enc_a", 1'b1, KEY_A, PT_A, CT_A, 57, 30, 97, 1'b1, 1'b1, 1'b0);
        release_start("enc_a", CT_A);
        run_op("enc_b", 1'b1, KEY_B, PT_B, CT_B, 97, 70, 97, 1'b0, 1'b0, 1'b0);
        release_start("enc_b", CT_B);

        // Cached-key operation aborted by RESET at edge 50.
        @(negedge CLK);
        mode = 1'b1;  key = KEY_B;  msg_in = PT_B;  start = 1'b1;
        @(posedge CLK);
        repeat (49) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;  start = 1'b0;
        @(posedge CLK);
        #1;
        chk("abort done", {done1, done4, donen}, 3'b000);
        chk("abort busy", {busy1, busy4, busyn}, 3'b000);
        chk_outs("abort", '0);
        @(negedge CLK);
        RESET = 1'b0;

        run_op("rerun_b", 1'b1, KEY_B, PT_B, CT_B, 97, 70, 97, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            chk("hold done", {done1, done4, donen}, 3'b111);
            chk("hold busy", {busy1, busy4, busyn}, 3'b000);
            chk("hold out1", out1, CT_B);
        end
        release_start("hold", CT_B);
        run_op("again_b", 1'b1, KEY_B, PT_B, CT_B, 57, 30, 97, 1'b1, 1'b1, 1'b0);
        release_start("again_b", CT_B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
